// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential Vedic multiplier: FSM encoding,
// default operand width and the digit-product cycle count.
package vedic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } vedic_state_t;

  localparam int VEDIC_DEFAULT_WIDTH = 8;

  // One 2x2 digit product per cycle, every A digit against every B digit.
  function automatic int mul_cycles(input int width);
    return (width / 2) * (width / 2);
  endfunction

endpackage

// File: rtl/vedic2bit.sv
// 2x2 Vedic (Urdhva-Tiryagbhyam) multiplier core: 2-bit A, 2-bit B, 4-bit M.
module vedic2bit (
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic [3:0] M
);

  logic cross_hi;
  logic cross_lo;
  logic carry1;

  assign cross_hi = A[1] & B[0];
  assign cross_lo = A[0] & B[1];
  assign carry1   = cross_hi & cross_lo;

  assign M[0] = A[0] & B[0];
  assign M[1] = cross_hi ^ cross_lo;
  assign M[2] = (A[1] & B[1]) ^ carry1;
  assign M[3] = (A[1] & B[1]) & carry1;

endmodule

// File: rtl/vedic_seq_mult.sv
// Sequential unsigned multiplier: one 2x2 Vedic digit product per cycle,
// accumulated into a 2*WIDTH result. Optional macro VEDIC_ZERO_SKIP_EN.
module vedic_seq_mult
  import vedic_pkg::*;
#(
  parameter int WIDTH = VEDIC_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] M
);

  localparam int DIGITS = WIDTH / 2;
  localparam int NCYC   = mul_cycles(WIDTH);
  localparam int CNT_W  = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW     = 2 * WIDTH;

  vedic_state_t     state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             last_cnt;
  logic [DIG_W-1:0] dig_i;
  logic [DIG_W-1:0] dig_j;
  logic [DIG_W:0]   dig_sum;
  logic [1:0]       a_dig;
  logic [1:0]       b_dig;
  logic [3:0]       pp;
  logic [PW-1:0]    pp_shifted;

  assign accept   = in_valid && in_ready;
  assign last_cnt = (cnt_q == CNT_W'(NCYC - 1));

  // cnt walks A digits fastest, then B digits.
  assign dig_i   = DIG_W'(int'(cnt_q) % DIGITS);
  assign dig_j   = DIG_W'(int'(cnt_q) / DIGITS);
  assign dig_sum = {1'b0, dig_i} + {1'b0, dig_j};
  assign a_dig   = a_q[{dig_i, 1'b0} +: 2];
  assign b_dig   = b_q[{dig_j, 1'b0} +: 2];

  vedic2bit u_core (
    .A (a_dig),
    .B (b_dig),
    .M (pp)
  );

  assign pp_shifted = PW'(pp) << {dig_sum, 1'b0};

`ifdef VEDIC_ZERO_SKIP_EN
  logic zero_op;
  assign zero_op = (A == '0) || (B == '0);
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef VEDIC_ZERO_SKIP_EN
          if (zero_op) state_d = ST_DONE;
          else         state_d = ST_MUL;
`else
          state_d = ST_MUL;
`endif
        end
      end
      ST_MUL:  if (last_cnt) state_d = ST_DONE;
      ST_DONE: if (out_valid && out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch, digit counter and accumulator.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept) begin
      a_d   = A;
      b_d   = B;
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == ST_MUL) begin
      acc_d = acc_q + pp_shifted;
      cnt_d = last_cnt ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Outputs.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    M         = acc_q;
  end

endmodule

// File: tb/tb_vedic_seq_mult.sv
// Directed, table-driven bench for vedic_seq_mult (WIDTH=8), plus hand-written
// reset-abort and back-to-back sequences. Honours VEDIC_ZERO_SKIP_EN.
module tb_vedic_seq_mult;

  localparam int W        = 8;
  localparam int FULL_LAT = 16;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] m;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] m;
    int          hold;
  } vec_t;

  vedic_seq_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .M         (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [7:0] av, input logic [7:0] bv);
`ifdef VEDIC_ZERO_SKIP_EN
    if (av == 8'd0 || bv == 8'd0) return 1;
`endif
    return FULL_LAT;
  endfunction

  // Called #1 after a rising edge with the DUT idle; returns the same way.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp_m, input int hold);
    int  lat;
    bit  seen;
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      a        = 8'($urandom);
      b        = 8'($urandom);
      @(posedge clk); #1;
      if (out_valid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_latency(av, bv)));
    chk({tag, "_M"}, 32'(m), 32'(exp_m));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_M"}, 32'(m), 32'(exp_m));
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_dropped"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    $display("op %s A=%0d B=%0d M=%0d latency=%0d hold=%0d", tag, av, bv, m, lat, hold);
  endtask

  initial begin
    vec_t vecs [10];
    int   lat;
    int   stray;
    bit   seen;

    vecs[0] = '{8'd3,   8'd5,   16'd15,    0};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01,  0};
    vecs[2] = '{8'd200, 8'd7,   16'd1400,  10};
    vecs[3] = '{8'd0,   8'd77,  16'd0,     0};
    vecs[4] = '{8'd77,  8'd0,   16'd0,     2};
    vecs[5] = '{8'd1,   8'd1,   16'd1,     0};
    vecs[6] = '{8'd128, 8'd2,   16'd256,   0};
    vecs[7] = '{8'd170, 8'd85,  16'd14450, 1};
    vecs[8] = '{8'd254, 8'd3,   16'd762,   0};
    vecs[9] = '{8'd15,  8'd240, 16'd3600,  0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    chk("reset_M", 32'(m), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    for (int k = 0; k < 10; k++) begin
      run_op($sformatf("vec%0d", k), vecs[k].a, vecs[k].b, vecs[k].m, vecs[k].hold);
      @(posedge clk); #1;
    end

    // Reset during MUL: operation is discarded with no result pulse.
    a        = 8'd100;
    b        = 8'd100;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_M", 32'(m), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    stray = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    chk("abort_no_valid", 32'(stray), 32'd0);
    $display("op abort A=100 B=100 reset at MUL cycle 8 M=%0d", m);
    run_op("after_abort", 8'd12, 8'd12, 16'd144, 0);
    @(posedge clk); #1;

    // Back-to-back with in_valid and out_ready held high.
    a         = 8'd17;
    b         = 8'd3;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b1_in_ready_busy", 32'(in_ready), 32'd0);
    a    = 8'd9;
    b    = 8'd9;
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    chk("b2b1_latency", 32'(lat), 32'(FULL_LAT));
    chk("b2b1_M", 32'(m), 32'd51);
    $display("op b2b1 A=17 B=3 M=%0d latency=%0d", m, lat);
    @(posedge clk); #1;
    chk("b2b_gap_out_valid", 32'(out_valid), 32'd0);
    chk("b2b_gap_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("b2b2_in_ready_busy", 32'(in_ready), 32'd0);
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    in_valid = 1'b0;
    chk("b2b2_latency", 32'(lat), 32'(FULL_LAT));
    chk("b2b2_M", 32'(m), 32'd81);
    $display("op b2b2 A=9 B=9 M=%0d latency=%0d", m, lat);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b2_consumed", 32'(out_valid), 32'd0);
    chk("b2b2_in_ready_after", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
